ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard.
//  Counterpart of the PS/2 receiver in perip; shares the open-drain PS2_CLK/PS2_DAT pair with it.
//  Runs the inhibit -> request-to-send -> device-clocked shift -> ack sequence, then hands the bus back.
//  Asserts rx_inhibit so the receiver ignores its own traffic.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles PS2_CLK is held low before RTS (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles between device clock falling edges (15 ms @ 50 MHz)
//  FILTER_LEN      4       consecutive equal samples needed to accept a PS2 line level change
// PORTS
//  clk         in   1  system clock (CLOCK_50 domain)
//  rst_n       in   1  asynchronous reset, active low
//  tx_valid    in   1  command byte offered
//  tx_data     in   8  command byte
//  tx_ready    out  1  block idle, accepts tx_data when tx_valid
//  done        out  1  one-cycle pulse, transfer finished (success or failure)
//  err         out  1  valid with done: 1 = no ack or timeout
//  busy        out  1  transfer in progress (state != IDLE)
//  rx_inhibit  out  1  receiver must discard frames while 1 (equals busy)
//  ps2_clk_i   in   1  raw PS2_CLK pad level (asynchronous)
//  ps2_dat_i   in   1  raw PS2_DAT pad level (asynchronous)
//  ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release
//  ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release
// BEHAVIOUR
//  Reset values: tx_ready=1, done=0, err=0, busy=0, rx_inhibit=0, ps2_clk_oe=0, ps2_dat_oe=0.
//  Reset mid-transfer releases both lines immediately. The filter also resets: history all-1, level 1.
//  Line inputs: 2-FF synchronizer, then FILTER_LEN glitch filter. fall = filtered clk 1->0 (one-cycle strobe).
//  Frame on the wire: start(0), d0..d7 LSB first, odd parity (~^data), stop(1), device ack(0).
//  Handshake: accept on tx_valid && tx_ready; tx_data latched, parity computed at accept.
//   tx_ready drops the next cycle. tx_valid outside IDLE is ignored.
//  FSM:
//   IDLE: on accept -> INHIBIT, cnt=0.
//   INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. Last cycle sets dat_oe=1 (start bit) -> RTS.
//   RTS: clk_oe=0, dat_oe=1. On fall -> SHIFT, bitcnt=0, and drive d0.
//   SHIFT: on each fall, bitcnt++ and drive the next bit (dat_oe = ~bit).
//    Falls 1..8 put d0..d7, fall 9 puts parity, fall 10 puts stop (dat_oe=0) -> ACK.
//   ACK: on fall 11, sample filtered dat: 0 -> ok, 1 -> err. -> WAIT_IDLE.
//   WAIT_IDLE: wait for filtered clk=1 and dat=1, then pulse done (with err) -> IDLE.
//  Timeout: in RTS/SHIFT/ACK/WAIT_IDLE a counter resets on every fall.
//   Reaching TIMEOUT_CYCLES: release both lines, done=1, err=1 -> IDLE.
//  Driven-bit changes take effect only on fall strobes, never on rising edges.
//  done/err are registered and asserted exactly one cycle. err holds its value until the next done.
//  Counters are sized by $clog2 of their parameter and saturate at terminal count, no wrap.
//  A fall seen during INHIBIT (our own clk_oe) is ignored.
// STRUCTURE
//  common.v: `define PS2_CMD_SET_LED 8'hED, `PS2_CMD_ENABLE 8'hF4, `PS2_ACK_BYTE 8'hFA.
//  FSM state encodings are localparams in this module.
//  Sub-module ps2_line_filter (synchronizer + FILTER_LEN glitch filter + fall strobe), one each for clk and dat.
//  perip instantiates this block beside the receiver. Pad = oe ? 1'b0 : 1'bz.
// TESTING  (sim params: INHIBIT_CYCLES=50, TIMEOUT_CYCLES=2000, FILTER_LEN=2; device BFM clocks with 40-cycle period)
//  1 Send 0xED, BFM acks -> wire bits 0,1,0,1,1,0,1,1,1,parity=1,stop=1. done=1 with err=0; lines released after.
//  2 Send 0xF4 -> BFM captures 0xF4 with parity=0. tx_ready returns 1 one cycle after done.
//  3 BFM omits ack (dat high at fall 11) -> done=1, err=1, ps2_dat_oe=0.
//  4 BFM stops clocking after fall 5 -> done=1, err=1 exactly 2000 cycles after the last fall; both oe=0.
//  5 rst_n low during SHIFT -> oe outputs 0 and tx_ready=1 asynchronously. Next 0xF4 send completes with err=0.
//  6 1-cycle glitch on ps2_clk_i during SHIFT -> no extra bit; frame still decodes correctly.
//    tx_valid held high through the whole frame -> exactly one transfer per accept.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter:
//   - well-known command / response bytes
//   - transmitter FSM state type
//   - small helpers for counter sizing and frame parity
// ----------------------------------------------------------------------------
package ps2_host_tx_pkg;

    // Command bytes a host typically sends, and the device's acknowledge byte.
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Bits the host shifts out after the start bit: d0..d7, parity, stop.
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,     // host pulls PS2_CLK low to abort any device traffic
        ST_RTS,         // clock released, data low: request-to-send
        ST_SHIFT,       // device clocks the frame out of us
        ST_ACK,         // waiting for the device's ack clock
        ST_WAIT_IDLE    // waiting for both lines to float high again
    } state_e;

    // Counter width for a counter that never needs to exceed n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // PS/2 uses odd parity: the nine bits d0..d7,parity hold an odd number of 1s.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_if
//   Command-side handshake of the PS/2 host transmitter.
//   master : client that issues command bytes
//   slave  : the transmitter itself
//   Signals:
//     tx_valid   command byte offered
//     tx_data    command byte
//     tx_ready   transmitter idle, accepts tx_data when tx_valid
//     done       one-cycle pulse, transfer finished
//     err        qualified by done: 1 = no ack or timeout
//     busy       transfer in progress
//     rx_inhibit receiver must discard frames while 1
// ----------------------------------------------------------------------------
interface ps2_host_tx_if;
    import ps2_host_tx_pkg::*;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       done;
    logic       err;
    logic       busy;
    logic       rx_inhibit;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, done, err, busy, rx_inhibit
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, done, err, busy, rx_inhibit
    );

endinterface

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
//   Conditions one raw PS/2 pad level for use in the clk domain:
//   two-flop synchronizer, then a glitch filter that only accepts a new level
//   after FILTER_LEN consecutive equal samples, then a 1->0 edge strobe.
//   Ports:
//     clk, rst_n  system clock, asynchronous active-low reset
//     line_i      raw pad level (asynchronous)
//     level       filtered line level
//     fall        one-cycle strobe on a filtered 1->0 transition
// ----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level,
    output logic fall
);
    import ps2_host_tx_pkg::*;

    logic                  sync_q1;
    logic                  sync_q2;
    logic [FILTER_LEN-1:0] hist;

    // NOTE: every register here resets to 1 (the idle level of an open-drain
    // PS/2 line), so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            hist    <= '1;
            level   <= 1'b1;
            fall    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the value
            // its predecessor held before this edge -- a true shift chain.
            sync_q1 <= line_i;
            sync_q2 <= sync_q1;
            // Newest sample enters at bit 0; the oldest one falls off the top.
            hist    <= FILTER_LEN'({hist, sync_q2});
            if (&hist) begin
                level <= 1'b1;
            end else if (~|hist) begin
                level <= 1'b0;
            end
            // level drops on the same edge, so the strobe lasts one cycle.
            fall    <= level & ~|hist;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the device on
//   the open-drain PS2_CLK/PS2_DAT pair shared with the PS/2 receiver:
//   inhibit -> request-to-send -> device-clocked shift -> ack -> bus idle.
//   rx_inhibit tells the receiver to ignore the traffic we generate.
//   Ports:
//     clk, rst_n   system clock, asynchronous active-low reset
//     cmd          command handshake (slave side of ps2_host_tx_if)
//     ps2_clk_i    raw PS2_CLK pad level
//     ps2_dat_i    raw PS2_DAT pad level
//     ps2_clk_oe   1 = pull PS2_CLK low, 0 = release
//     ps2_dat_oe   1 = pull PS2_DAT low, 0 = release
//   Parameters:
//     INHIBIT_CYCLES  cycles PS2_CLK is held low before request-to-send
//     TIMEOUT_CYCLES  max cycles between device clock falling edges
//     FILTER_LEN      equal samples needed to accept a line level change
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_host_tx_if.slave   cmd,
    input  logic           ps2_clk_i,
    input  logic           ps2_dat_i,
    output logic           ps2_clk_oe,
    output logic           ps2_dat_oe
);
    import ps2_host_tx_pkg::*;

    localparam int unsigned INH_W = cnt_width(INHIBIT_CYCLES);
    localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    // Fall number 10 (the stop bit) happens with bit_cnt at this value.
    localparam logic [3:0] STOP_CNT = 4'd8;

    // ---------------------------------------------------------------- lines
    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic unused_dat_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (ps2_clk_i),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (ps2_dat_i),
        .level  (dat_level),
        .fall   (unused_dat_fall)
    );

    // ------------------------------------------------------------------ FSM
    state_e                      state;
    logic [INH_W-1:0]            inh_cnt;
    logic [TO_W-1:0]             to_cnt;
    logic [3:0]                  bit_cnt;
    logic [FRAME_BITS-1:0]       shreg;    // {stop, parity, d7..d0}, LSB goes out next
    logic                        nack;     // ack result held until done
    logic                        tx_ready_q;
    logic                        done_q;
    logic                        err_q;
    logic                        busy_q;
    logic                        clk_oe_q;
    logic                        dat_oe_q;

    logic device_phase;
    logic timeout_hit;

    // The device owns the clock in these states; a missing fall means it is
    // gone or confused. The fall strobe wins over a coincident terminal count.
    assign device_phase = (state == ST_RTS)   || (state == ST_SHIFT) ||
                          (state == ST_ACK)   || (state == ST_WAIT_IDLE);
    assign timeout_hit  = device_phase && !clk_fall && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '1;
            nack       <= 1'b0;
            tx_ready_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Free-running gap counter: cleared by every device clock fall,
            // saturating so it can never wrap back into range.
            if (clk_fall) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (timeout_hit) begin
                state    <= ST_IDLE;
                done_q   <= 1'b1;
                err_q    <= 1'b1;
                busy_q   <= 1'b0;
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd.tx_valid && tx_ready_q) begin
                            shreg      <= {1'b1, odd_parity(cmd.tx_data), cmd.tx_data};
                            inh_cnt    <= '0;
                            tx_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            clk_oe_q   <= 1'b1;
                            state      <= ST_INHIBIT;
                        end else begin
                            // Re-armed one cycle after done.
                            tx_ready_q <= 1'b1;
                        end
                    end

                    // Our own clk_oe produces a filtered fall here; this state
                    // does not look at clk_fall, so it is ignored.
                    ST_INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            clk_oe_q <= 1'b0;
                            dat_oe_q <= 1'b1;    // start bit
                            to_cnt   <= '0;
                            state    <= ST_RTS;
                        end else begin
                            inh_cnt  <= inh_cnt + INH_W'(1);
                        end
                    end

                    // Fall 1 puts d0 on the line.
                    ST_RTS: begin
                        if (clk_fall) begin
                            dat_oe_q <= ~shreg[0];
                            shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
                            bit_cnt  <= '0;
                            state    <= ST_SHIFT;
                        end
                    end

                    // Falls 2..10 put d1..d7, parity, stop. Bits only change
                    // on falls, so the device always samples a settled line
                    // on its rising edge.
                    ST_SHIFT: begin
                        if (clk_fall) begin
                            dat_oe_q <= ~shreg[0];
                            shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
                            if (bit_cnt == STOP_CNT) begin
                                state   <= ST_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // Fall 11: the device should be holding data low.
                    ST_ACK: begin
                        if (clk_fall) begin
                            nack  <= dat_level;
                            state <= ST_WAIT_IDLE;
                        end
                    end

                    ST_WAIT_IDLE: begin
                        if (clk_level && dat_level) begin
                            done_q   <= 1'b1;
                            err_q    <= nack;
                            busy_q   <= 1'b0;
                            clk_oe_q <= 1'b0;
                            dat_oe_q <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end

                    default: begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign cmd.tx_ready   = tx_ready_q;
    assign cmd.done       = done_q;
    assign cmd.err        = err_q;
    assign cmd.busy       = busy_q;
    assign cmd.rx_inhibit = busy_q;
    assign ps2_clk_oe     = clk_oe_q;
    assign ps2_dat_oe     = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Self-checking bench for ps2_host_tx. A behavioural PS/2 device generates
//   the clock (40-cycle period), samples host bits on its rising edges and
//   optionally acknowledges. Expected frames come from a byte-level model.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH      = 50;
    localparam int TO       = 2000;
    localparam int FL       = 2;
    localparam int HALF     = 20;
    // Pad edge -> FSM reaction: 2 sync flops, FL filter samples, level/strobe
    // register, FSM register.
    localparam int FALL_LAT = FL + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bfm_clk = 1'b1;
    logic bfm_dat = 1'b1;
    logic glitch  = 1'b0;
    logic ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_i = ~ps2_clk_oe & bfm_clk & ~glitch;
    assign ps2_dat_i = ~ps2_dat_oe & bfm_dat;

    ps2_host_tx_if cmd ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #10 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_fall_cyc = 0;
    int   accept_cnt = 0;
    logic busy_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every accepted command shows up as one rising edge of busy.
    always @(posedge clk) begin
        #1;
        busy_d <= cmd.busy;
        if (cmd.busy && !busy_d) accept_cnt <= accept_cnt + 1;
    end

    // ------------------------------------------------------------ model
    // Wire image seen by the device: [0]=start, [1..8]=d0..d7, [9]=parity, [10]=stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // ------------------------------------------------------------ stimulus
    task automatic send_byte(input logic [7:0] d, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd.tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (cmd.tx_ready !== 1'b1) begin
            $display("FAIL send_ready: tx_ready=%b after %0d cycles, required 1", cmd.tx_ready, w);
        end else begin
            n_pass++;
        end
        cmd.tx_data  = d;
        cmd.tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) cmd.tx_valid = 1'b0;
        n_checks++;
        if ({cmd.tx_ready, cmd.busy, cmd.rx_inhibit} !== 3'b011) begin
            $display("FAIL accept_flags: ready/busy/rx_inhibit=%b, required 011",
                     {cmd.tx_ready, cmd.busy, cmd.rx_inhibit});
        end else begin
            n_pass++;
        end
    endtask

    // Device BFM: waits for request-to-send, then issues n_clocks clock
    // pulses (11 = full frame incl. ack). glitch_at>0 injects a one-cycle low
    // pulse on PS2_CLK in that pulse's high phase.
    task automatic bfm_run(input int n_clocks, input bit ack, input int glitch_at,
                           output logic [10:0] cap);
        int w;
        w   = 0;
        cap = '1;
        while (!(ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) return;
        cap[0] = ps2_dat_i;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= n_clocks && i <= 11; i++) begin
            bfm_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            bfm_clk = 1'b1;
            if (i <= 10) cap[i] = ps2_dat_i;
            if (i == 11) begin
                @(negedge clk);
                bfm_dat = 1'b1;
                return;
            end
            for (int k = 0; k < HALF; k++) begin
                @(negedge clk);
                glitch = (i == glitch_at) && (k == 8);
                if (i == 10 && ack && k == 10) bfm_dat = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit got, output logic e, output int at);
        int i;
        got = 1'b0;
        e   = 1'bx;
        at  = 0;
        i   = 0;
        while (!got && i < limit) begin
            @(posedge clk);
            #1;
            if (cmd.done === 1'b1) begin
                got = 1'b1;
                e   = cmd.err;
                at  = cyc;
            end
            i++;
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd.tx_ready, cmd.done, cmd.err, cmd.busy, cmd.rx_inhibit, ps2_clk_oe, ps2_dat_oe} !== 7'b1000000)
            $display("FAIL reset_values: ready,done,err,busy,inh,clk_oe,dat_oe=%b, required 1000000",
                     {cmd.tx_ready, cmd.done, cmd.err, cmd.busy, cmd.rx_inhibit, ps2_clk_oe, ps2_dat_oe});
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({cmd.tx_ready, cmd.busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000)
            $display("FAIL post_reset_idle: ready,busy,clk_oe,dat_oe=%b, required 1000",
                     {cmd.tx_ready, cmd.busy, ps2_clk_oe, ps2_dat_oe});
        else n_pass++;
    endtask

    task automatic test_set_led();
        logic [10:0] cap;
        bit got;
        logic e;
        int at, inh;
        send_byte(PS2_CMD_SET_LED, 1'b0);
        inh = ps2_clk_oe ? 1 : 0;
        while (ps2_clk_oe && inh < 500) begin
            @(posedge clk);
            #1;
            if (ps2_clk_oe) inh++;
        end
        n_checks++;
        if (inh != INH) $display("FAIL inhibit_len: clk_oe high %0d cycles, required %0d", inh, INH);
        else n_pass++;
        n_checks++;
        if (ps2_dat_oe !== 1'b1) $display("FAIL rts_start: dat_oe=%b, required 1", ps2_dat_oe);
        else n_pass++;
        bfm_run(11, 1'b1, 0, cap);
        n_checks++;
        if (cap !== model_frame(PS2_CMD_SET_LED))
            $display("FAIL led_frame: wire=%b, required %b", cap, model_frame(PS2_CMD_SET_LED));
        else n_pass++;
        wait_done(500, got, e, at);
        n_checks++;
        if (!got || e !== 1'b0) $display("FAIL led_done: done=%b err=%b, required done=1 err=0", got, e);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({cmd.done, cmd.err, ps2_clk_oe, ps2_dat_oe} !== 4'b0000)
            $display("FAIL led_after: done,err,clk_oe,dat_oe=%b, required 0000",
                     {cmd.done, cmd.err, ps2_clk_oe, ps2_dat_oe});
        else n_pass++;
    endtask

    task automatic test_enable();
        logic [10:0] cap;
        bit got;
        logic e;
        int at;
        send_byte(PS2_CMD_ENABLE, 1'b0);
        bfm_run(11, 1'b1, 0, cap);
        n_checks++;
        if (cap !== model_frame(PS2_CMD_ENABLE))
            $display("FAIL enable_frame: wire=%b, required %b", cap, model_frame(PS2_CMD_ENABLE));
        else n_pass++;
        wait_done(500, got, e, at);
        n_checks++;
        if (!got || e !== 1'b0 || cmd.tx_ready !== 1'b0)
            $display("FAIL enable_done: done=%b err=%b ready=%b, required 1 0 0", got, e, cmd.tx_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd.tx_ready !== 1'b1 || cmd.err !== 1'b0)
            $display("FAIL ready_return: tx_ready=%b err=%b, required 1 0", cmd.tx_ready, cmd.err);
        else n_pass++;
    endtask

    task automatic test_no_ack();
        logic [10:0] cap;
        bit got;
        logic e;
        int at;
        send_byte(8'h5A, 1'b0);
        bfm_run(11, 1'b0, 0, cap);
        wait_done(500, got, e, at);
        n_checks++;
        if (!got || e !== 1'b1 || ps2_dat_oe !== 1'b0)
            $display("FAIL no_ack: done=%b err=%b dat_oe=%b, required 1 1 0", got, e, ps2_dat_oe);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if (cmd.err !== 1'b1) $display("FAIL err_hold: err=%b, required 1", cmd.err);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [10:0] cap;
        bit got;
        logic e;
        int at;
        send_byte(8'hA3, 1'b0);
        bfm_run(5, 1'b0, 0, cap);
        wait_done(TO + 200, got, e, at);
        n_checks++;
        if (!got || e !== 1'b1) $display("FAIL timeout_done: done=%b err=%b, required 1 1", got, e);
        else n_pass++;
        n_checks++;
        if (at - last_fall_cyc != TO + FALL_LAT)
            $display("FAIL timeout_time: %0d cycles after pad fall, required %0d", at - last_fall_cyc, TO + FALL_LAT);
        else n_pass++;
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00)
            $display("FAIL timeout_release: clk_oe,dat_oe=%b, required 00", {ps2_clk_oe, ps2_dat_oe});
        else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        logic [10:0] cap;
        bit got;
        logic e;
        int at;
        send_byte(8'h3C, 1'b0);
        bfm_run(3, 1'b1, 0, cap);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ps2_clk_oe, ps2_dat_oe, cmd.tx_ready, cmd.busy} !== 4'b0010)
            $display("FAIL async_reset: clk_oe,dat_oe,ready,busy=%b, required 0010",
                     {ps2_clk_oe, ps2_dat_oe, cmd.tx_ready, cmd.busy});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(PS2_CMD_ENABLE, 1'b0);
        bfm_run(11, 1'b1, 0, cap);
        wait_done(500, got, e, at);
        n_checks++;
        if (cap !== model_frame(PS2_CMD_ENABLE) || !got || e !== 1'b0)
            $display("FAIL after_reset: wire=%b done=%b err=%b, required %b 1 0",
                     cap, got, e, model_frame(PS2_CMD_ENABLE));
        else n_pass++;
    endtask

    task automatic test_glitch_held_valid();
        logic [10:0] cap;
        bit got;
        logic e;
        int at, a0;
        a0 = accept_cnt;
        send_byte(8'h96, 1'b1);
        bfm_run(11, 1'b1, 4, cap);
        wait_done(500, got, e, at);
        cmd.tx_valid = 1'b0;
        n_checks++;
        if (cap !== model_frame(8'h96) || !got || e !== 1'b0)
            $display("FAIL glitch_frame: wire=%b done=%b err=%b, required %b 1 0",
                     cap, got, e, model_frame(8'h96));
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (accept_cnt - a0 != 1 || cmd.busy !== 1'b0)
            $display("FAIL one_accept: accepts=%0d busy=%b, required 1 0", accept_cnt - a0, cmd.busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [10:0] cap;
        logic [7:0]  d;
        bit got, ack;
        logic e;
        int at;
        for (int n = 0; n < 6; n++) begin
            d   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            send_byte(d, 1'b0);
            bfm_run(11, ack, 0, cap);
            wait_done(500, got, e, at);
            n_checks++;
            if (cap !== model_frame(d))
                $display("FAIL rand_frame[%0d]: byte %h wire=%b, required %b", n, d, cap, model_frame(d));
            else n_pass++;
            n_checks++;
            if (!got || e !== !ack)
                $display("FAIL rand_done[%0d]: done=%b err=%b, required 1 %b", n, got, e, !ack);
            else n_pass++;
        end
    endtask

    initial begin
        cmd.tx_valid = 1'b0;
        cmd.tx_data  = 8'h00;
        test_reset();
        test_set_led();
        test_enable();
        test_no_ack();
        test_timeout();
        test_reset_mid_shift();
        test_glitch_held_valid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
